// File: rtl/cadence_pkg.sv
// cadence_pkg: shared state, scaling and configuration types for the cadence emulator
package cadence_pkg;
   typedef enum logic [1:0] {IDLE, BOUNCE, HOLD} state_t;
   localparam int SCALE_SH = 7;
   localparam int PER_WM = 32;
   localparam int BNC_WM = 16;
   typedef struct packed {
      logic [PER_WM-1:0] half_per;
      logic [BNC_WM-1:0] bnc_cnt;
      logic [7:0]        bnc_len;
   } cfg_t;
endpackage

// File: rtl/cadence_gen_if.sv
// cadence_gen_if: control and status bundle of the cadence emulator
interface cadence_gen_if #(
   parameter int PER_W = 16,
   parameter int BNC_W = 4
);
   logic             en;
   logic             ld;
   logic [PER_W-1:0] half_per;
   logic [BNC_W-1:0] bnc_cnt;
   logic [7:0]       bnc_len;
   logic             cfg_pend;
   logic             cadence;
   logic             edge_done;
   logic [7:0]       rev_cnt;
   modport master (output en, ld, half_per, bnc_cnt, bnc_len, input cfg_pend, cadence, edge_done, rev_cnt);
   modport slave (input en, ld, half_per, bnc_cnt, bnc_len, output cfg_pend, cadence, edge_done, rev_cnt);
endinterface

// File: rtl/cadence_bounce_seq.sv
// cadence_bounce_seq: glitch-width and glitch-pair counters for one bounced edge
module cadence_bounce_seq #(
   parameter int BNC_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [BNC_W-1:0] bnc_cnt,
   input  logic [7:0]       bnc_len,
   output logic             done,
   output logic             ph
);
   logic [7:0]       wcnt;
   logic [BNC_W-1:0] pcnt;
   logic             wlast;
   assign wlast = wcnt == (bnc_len == 8'd0 ? 8'd0 : bnc_len - 8'd1);
   assign done = ph && wlast && pcnt == bnc_cnt - BNC_W'(1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wcnt <= '0;
         pcnt <= '0;
         ph <= 1'b0;
      end else if (start) begin
         wcnt <= '0;
         pcnt <= '0;
         ph <= 1'b0;
      end else if (wlast) begin
         wcnt <= '0;
         ph <= ~ph;
         pcnt <= pcnt + BNC_W'(ph);
      end else begin
         wcnt <= wcnt + 8'd1;
      end
endmodule

// File: rtl/cadence_gen.sv
// cadence_gen: programmable pedal-cadence square-wave emulator with contact-bounce injection
module cadence_gen
   import cadence_pkg::*;
#(
   parameter int FAST_SIM = 1,
   parameter int PER_W = 16,
   parameter int BNC_W = 4
) (
   input logic         clk,
   input logic         rst_n,
   cadence_gen_if.slave bus
);
   localparam int HW = PER_W + 7;
   localparam int SH = FAST_SIM != 0 ? 0 : SCALE_SH;
   state_t        state;
   cfg_t          shadow, act, eff;
   logic [HW-1:0] hold_cnt, hold_len;
   logic [7:0]    rev_q;
   logic          tgt, rise_q, cad_q, done_q, pend_q;
   logic          run, halt, hold_end, zstop, edge_go, rise_go, reload, start, bdone, ph, lvl;
   assign eff = pend_q ? shadow : act;
   assign hold_len = HW'(act.half_per[PER_W-1:0]) << SH;
   assign run = state != IDLE;
   assign halt = run && (!bus.en || act.half_per == '0);
   assign hold_end = state == HOLD && hold_cnt == hold_len - HW'(1);
   // a pending zero half-period ends the run at the next rising edge instead of starting it
   assign zstop = hold_end && !tgt && eff.half_per == '0 && !halt;
   assign edge_go = !halt && (run ? hold_end && (tgt || eff.half_per != '0) : bus.en && eff.half_per != '0);
   assign rise_go = edge_go && (!run || !tgt);
   assign reload = rise_go || zstop;
   assign start = edge_go && (rise_go ? eff.bnc_cnt : act.bnc_cnt) != '0;
   assign lvl = state == HOLD ? tgt : state == BOUNCE && (tgt ^ ph);
   cadence_bounce_seq #(.BNC_W(BNC_W)) u_seq (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .bnc_cnt (act.bnc_cnt[BNC_W-1:0]),
      .bnc_len (act.bnc_len),
      .done    (bdone),
      .ph      (ph)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         shadow <= '0;
         act <= '0;
         hold_cnt <= '0;
         tgt <= 1'b0;
         rise_q <= 1'b0;
         cad_q <= 1'b0;
         done_q <= 1'b0;
         pend_q <= 1'b0;
         rev_q <= '0;
      end else begin
         if (bus.ld) shadow <= '{half_per: PER_WM'(bus.half_per), bnc_cnt: BNC_WM'(bus.bnc_cnt), bnc_len: bus.bnc_len};
         if (reload) act <= eff;
         pend_q <= bus.ld || (pend_q && !reload);
         rise_q <= rise_go;
         rev_q <= rev_q + 8'(rise_q);
         cad_q <= !halt && lvl;
         done_q <= !halt && state == HOLD && hold_cnt == '0;
         hold_cnt <= state == HOLD && !hold_end ? hold_cnt + HW'(1) : '0;
         if (halt || zstop) state <= IDLE;
         else if (edge_go) begin
            tgt <= rise_go;
            state <= start ? BOUNCE : HOLD;
         end else if (state == BOUNCE && bdone) state <= HOLD;
      end
   assign bus.cadence = cad_q;
   assign bus.edge_done = done_q;
   assign bus.cfg_pend = pend_q;
   assign bus.rev_cnt = rev_q;
endmodule

// File: tb/tb_cadence_gen.sv
// tb_cadence_gen: randomized bench against a waveform-queue model of the cadence emulator
module tb_cadence_gen;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0, ld = 1'b0, en2 = 1'b0, ld2 = 1'b0;
   logic [15:0] hp = '0;
   logic [3:0]  bc = '0;
   logic [7:0]  bl = '0;
   int          n_chk = 0, n_err = 0;
   logic [1:0]  q[$];
   int          m_hp, m_bc, m_bl, s_hp, s_bc, s_bl, m_rev;
   bit          m_pend, m_cad, m_ed, m_tgt, m_rise;
   cadence_gen_if #(.PER_W(16), .BNC_W(4)) b();
   cadence_gen_if #(.PER_W(16), .BNC_W(4)) b2();
   assign b.en = en;
   assign b.ld = ld;
   assign b.half_per = hp;
   assign b.bnc_cnt = bc;
   assign b.bnc_len = bl;
   assign b2.en = en2;
   assign b2.ld = ld2;
   assign b2.half_per = 16'd4;
   assign b2.bnc_cnt = 4'd0;
   assign b2.bnc_len = 8'd0;
   cadence_gen #(.FAST_SIM(1), .PER_W(16), .BNC_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
   cadence_gen #(.FAST_SIM(0), .PER_W(16), .BNC_W(4)) dut_slow (.clk(clk), .rst_n(rst_n), .bus(b2));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      q.delete();
      {m_hp, m_bc, m_bl, s_hp, s_bc, s_bl, m_rev} = '0;
      {m_pend, m_cad, m_ed, m_tgt, m_rise} = '0;
   endtask
   // one half-period: bnc_cnt pairs of (new level, old level) glitches, then the steady hold
   task automatic fill(input bit t);
      int l;
      l = m_bl == 0 ? 1 : m_bl;
      for (int p = 0; p < m_bc; p++) begin
         for (int i = 0; i < l; i++) q.push_back({t, 1'b0});
         for (int i = 0; i < l; i++) q.push_back({~t, 1'b0});
      end
      for (int i = 0; i < m_hp; i++) q.push_back({t, i == 0});
   endtask
   task automatic model_edge();
      logic [1:0] v;
      bit running;
      int e_hp, e_bc, e_bl;
      running = q.size() != 0;
      if (m_rise) m_rev = (m_rev + 1) % 256;
      m_rise = 0;
      if (running && !en) begin
         q.delete();
         m_cad = 0;
         m_ed = 0;
      end else begin
         v = 2'b00;
         if (running) v = q.pop_front();
         m_cad = v[1];
         m_ed = v[0];
         if (q.size() == 0 && (running || en)) begin
            if (running && m_tgt) begin
               m_tgt = 0;
               fill(0);
            end else begin
               e_hp = m_pend ? s_hp : m_hp;
               e_bc = m_pend ? s_bc : m_bc;
               e_bl = m_pend ? s_bl : m_bl;
               if (e_hp != 0 || running) begin
                  m_hp = e_hp;
                  m_bc = e_bc;
                  m_bl = e_bl;
                  m_pend = 0;
               end
               if (e_hp != 0) begin
                  m_tgt = 1;
                  m_rise = 1;
                  fill(1);
               end
            end
         end
      end
      if (ld) begin
         s_hp = hp;
         s_bc = bc;
         s_bl = bl;
         m_pend = 1;
      end
   endtask
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("cadence", 32'(b.cadence), 32'(m_cad));
      check("edge_done", 32'(b.edge_done), 32'(m_ed));
      check("rev_cnt", 32'(b.rev_cnt), 32'(m_rev));
      check("cfg_pend", 32'(b.cfg_pend), 32'(m_pend));
      ld = 1'b0;
   endtask
   task automatic check_zero(input string tag);
      check({tag, "_cadence"}, 32'(b.cadence), 0);
      check({tag, "_edge_done"}, 32'(b.edge_done), 0);
      check({tag, "_rev_cnt"}, 32'(b.rev_cnt), 0);
      check({tag, "_cfg_pend"}, 32'(b.cfg_pend), 0);
   endtask
   initial begin
      int len, hi, lo;
      bit prev;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      ld = 1'b1; hp = 16'd10; bc = 4'd0; bl = 8'd0;
      step();
      en = 1'b1;
      repeat (60) step();
      for (int i = 0; i < 40; i++) begin
         if (m_cad && q.size() > 3) break;
         step();
      end
      ld = 1'b1; hp = 16'd8;
      step();
      repeat (60) step();
      ld = 1'b1; hp = 16'd20; bc = 4'd3; bl = 8'd2;
      step();
      repeat (150) step();
      for (int i = 0; i < 200; i++) begin
         if (m_bc != 0 && q.size() > m_hp + 2) break;
         step();
      end
      en = 1'b0;
      step();
      check("stop_cadence", 32'(b.cadence), 0);
      check("stop_edge_done", 32'(b.edge_done), 0);
      repeat (5) step();
      en = 1'b1;
      repeat (120) step();
      ld = 1'b1; hp = 16'd0;
      step();
      repeat (150) step();
      repeat (25) begin
         ld = 1'b1;
         hp = 16'($urandom_range(1, 12));
         bc = 4'($urandom_range(0, 3));
         bl = 8'($urandom_range(0, 3));
         en = 1'b1;
         repeat ($urandom_range(20, 120)) begin
            if ($urandom_range(0, 60) == 0) en = ~en;
            if ($urandom_range(0, 24) == 0) begin
               ld = 1'b1;
               hp = 16'($urandom_range(0, 10));
               bc = 4'($urandom_range(0, 3));
               bl = 8'($urandom_range(0, 3));
            end
            step();
         end
      end
      en = 1'b1;
      ld = 1'b1; hp = 16'd1; bc = 4'd0; bl = 8'd0;
      step();
      repeat (600) step();
      ld = 1'b1; hp = 16'd20;
      step();
      repeat (45) step();
      check("pre_reset_cadence", 32'(b.cadence), 32'(m_cad));
      #2 rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      model_reset();
      en = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      repeat (3) step();
      ld2 = 1'b1;
      step();
      ld2 = 1'b0;
      en2 = 1'b1;
      len = 0; hi = -1; lo = -1; prev = 1'b0;
      for (int i = 0; i < 3000 && lo < 0; i++) begin
         step();
         if (b2.cadence == prev) len++;
         else begin
            if (prev) hi = len;
            else if (hi >= 0) lo = len;
            len = 1;
         end
         prev = b2.cadence;
      end
      check("slow_high_len", hi, 512);
      check("slow_low_len", lo, 512);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
